// File: rtl/bus_decode_pkg.sv
// Address map, FSM states and decode helper shared by the 68030 bus decoder.
package pg68k_bus_pkg;

   localparam logic [31:0] ROM_BASE_DEF   = 32'hF000_0000;
   localparam logic [31:0] IO_BASE_DEF    = 32'hF010_0000;
   localparam int unsigned WIN_SHIFT      = 20;  // 1 MB windows
   localparam int unsigned RAM_UNIT_SHIFT = 24;  // 16 MB RAM units
   localparam logic [2:0]  FC_CPU_SPACE   = 3'b111;
   localparam logic [4:0]  RAMTOP_MAX     = 5'd16;

   typedef enum logic [2:0] {
      ST_WAITNEG,
      ST_IDLE,
      ST_ACTIVE,
      ST_TERM,
      ST_TIMEOUT
   } bus_state_e;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_ROM,
      SEL_IO
   } sel_e;

   typedef struct packed {
      sel_e sel;
      logic native_rom;
   } decode_t;

   function automatic decode_t decode(
      input logic [2:0]  fc,
      input logic        rnw,
      input logic [31:0] addr,
      input logic [4:0]  ramtop,
      input logic        overlay,
      input logic [31:0] rom_base,
      input logic [31:0] io_base
   );
      decode_t    d;
      logic [4:0] top;
      top          = (ramtop > RAMTOP_MAX) ? RAMTOP_MAX : ramtop;
      d.sel        = SEL_NONE;
      d.native_rom = 1'b0;
      if (fc == FC_CPU_SPACE) begin
         d.sel = SEL_NONE;
      end else if (overlay && rnw && (addr[31:WIN_SHIFT] == '0)) begin
         d.sel = SEL_ROM;
      end else if ((addr[31:RAM_UNIT_SHIFT+4] == '0) &&
                   ({1'b0, addr[RAM_UNIT_SHIFT+3:RAM_UNIT_SHIFT]} < top)) begin
         d.sel = SEL_RAM;
      end else if (addr[31:WIN_SHIFT] == rom_base[31:WIN_SHIFT]) begin
         d.sel        = SEL_ROM;
         d.native_rom = 1'b1;
      end else if (addr[31:WIN_SHIFT] == io_base[31:WIN_SHIFT]) begin
         d.sel = SEL_IO;
      end
      return d;
   endfunction

endpackage

// File: rtl/bus_decode_if.sv
// CPU-side bus signals seen by the address decoder and its selects.
interface bus_decode_if;
   logic        cpu_nAS;
   logic        RnW;
   logic [2:0]  FC;
   logic [31:0] ADDR;
   logic [4:0]  RAMTOP;
   logic        TERM_ANY;
   logic        nRAMSEL;
   logic        nROMSEL;
   logic        nIOSEL;
   logic        BERR;
   logic        OVERLAY;

   modport master (
      output cpu_nAS, RnW, FC, ADDR, RAMTOP, TERM_ANY,
      input  nRAMSEL, nROMSEL, nIOSEL, BERR, OVERLAY
   );

   modport slave (
      input  cpu_nAS, RnW, FC, ADDR, RAMTOP, TERM_ANY,
      output nRAMSEL, nROMSEL, nIOSEL, BERR, OVERLAY
   );
endinterface

// File: rtl/bus_decode_watchdog.sv
// Bus watchdog: synchronises the termination OR and counts cycles without termination.
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 9
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic term_async_i,
   input  logic start_i,
   input  logic active_i,
   output logic term_s_o,
   output logic timeout_o
);

   logic             term_meta_q;
   logic             term_s_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = '0;
      end else if (active_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         term_meta_q <= 1'b0;
         term_s_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         term_meta_q <= term_async_i;
         term_s_q    <= term_meta_q;
         cnt_q       <= cnt_d;
      end
   end

   assign term_s_o  = term_s_q;
   assign timeout_o = active_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_decode.sv
// 68030 address decoder and bus-cycle supervisor: RAM/ROM/IO selects, boot overlay, BERR watchdog.
module bus_decode
   import pg68k_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ROM_BASE       = ROM_BASE_DEF,
   parameter logic [31:0] IO_BASE        = IO_BASE_DEF,
   parameter int unsigned CNT_W          = 9
) (
   input  logic         CLK,
   input  logic         RST,
   bus_decode_if.slave  bus
);

   logic       as_meta_q;
   logic       as_s_q;
   logic [1:0] sync_vld_q;
   bus_state_e state_q, state_d;
   sel_e       sel_q, sel_d;
   logic       berr_q, berr_d;
   logic       overlay_q, overlay_d;
   logic       rom_win_q, rom_win_d;
   logic       wd_start;
   logic       wd_active;
   logic       term_s;
   logic       timeout;
   decode_t    dec;

   bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_watchdog (
      .clk_i        (CLK),
      .rst_i        (RST),
      .term_async_i (bus.TERM_ANY),
      .start_i      (wd_start),
      .active_i     (wd_active),
      .term_s_o     (term_s),
      .timeout_o    (timeout)
   );

   assign wd_active = (state_q == ST_ACTIVE) || (state_q == ST_TIMEOUT);
   assign dec = decode(bus.FC, bus.RnW, bus.ADDR, bus.RAMTOP, overlay_q, ROM_BASE, IO_BASE);

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      berr_d    = berr_q;
      overlay_d = overlay_q;
      rom_win_d = rom_win_q;
      wd_start  = 1'b0;
      unique case (state_q)
         // The sync flops reset to "negated", so AS_s is only trusted once both
         // stages hold a real sample; otherwise an in-flight cycle would be decoded.
         ST_WAITNEG: begin
            if (sync_vld_q[1] && !as_s_q) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (as_s_q) begin
               sel_d     = dec.sel;
               rom_win_d = dec.native_rom;
               wd_start  = 1'b1;
               state_d   = ST_ACTIVE;
            end
         end
         ST_ACTIVE, ST_TERM, ST_TIMEOUT: begin
            if (!as_s_q) begin
               state_d   = ST_IDLE;
               sel_d     = SEL_NONE;
               berr_d    = 1'b0;
               rom_win_d = 1'b0;
               if (rom_win_q) overlay_d = 1'b0;
            end else if (state_q == ST_ACTIVE) begin
               if (term_s) begin
                  state_d = ST_TERM;
               end else if (timeout) begin
                  berr_d  = 1'b1;
                  state_d = ST_TIMEOUT;
               end
            end
         end
         default: state_d = ST_WAITNEG;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         as_meta_q  <= 1'b0;
         as_s_q     <= 1'b0;
         sync_vld_q <= '0;
         state_q    <= ST_WAITNEG;
         sel_q      <= SEL_NONE;
         berr_q     <= 1'b0;
         overlay_q  <= 1'b1;
         rom_win_q  <= 1'b0;
      end else begin
         as_meta_q  <= ~bus.cpu_nAS;
         as_s_q     <= as_meta_q;
         sync_vld_q <= {sync_vld_q[0], 1'b1};
         state_q    <= state_d;
         sel_q      <= sel_d;
         berr_q     <= berr_d;
         overlay_q  <= overlay_d;
         rom_win_q  <= rom_win_d;
      end
   end

   assign bus.nRAMSEL = (sel_q != SEL_RAM);
   assign bus.nROMSEL = (sel_q != SEL_ROM);
   assign bus.nIOSEL  = (sel_q != SEL_IO);
   assign bus.BERR    = berr_q;
   assign bus.OVERLAY = overlay_q;

endmodule

// File: tb/tb_bus_decode.sv
// Directed bench for bus_decode with a cycle-level behavioural model and per-cycle compare.
module tb_bus_decode;

   localparam int unsigned TMO = 256;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   bus_decode_if bus_if ();

   bus_decode #(
      .TIMEOUT_CYCLES (TMO),
      .ROM_BASE       (32'hF000_0000),
      .IO_BASE        (32'hF010_0000),
      .CNT_W          (9)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit m_valid;
   bit m_as_p1, m_as_p2, m_tm_p1, m_tm_p2;
   int m_primed;
   bit m_waitneg, m_in_bus, m_done, m_native;
   int m_age;
   int m_sel;            // 0 none, 1 ram, 2 rom, 3 io
   bit m_berr, m_ovl;

   function automatic int model_sel(input logic [31:0] addr, input logic rnw,
                                    input logic [2:0] fc, input logic [4:0] ramtop,
                                    input bit ovl, output bit native);
      longint unsigned a, ram_limit;
      int unsigned top;
      native    = 0;
      a         = longint'(addr);
      top       = (ramtop > 16) ? 16 : int'(ramtop);
      ram_limit = longint'(top) * 64'd16777216;
      if (fc == 3'd7) return 0;
      if (ovl && rnw && a < 64'h0010_0000) return 2;
      if (a < ram_limit) return 1;
      if (a >= 64'hF000_0000 && a < 64'hF010_0000) begin
         native = 1;
         return 2;
      end
      if (a >= 64'hF010_0000 && a < 64'hF020_0000) return 3;
      return 0;
   endfunction

   task automatic model_step();
      bit as_s, term_s, nat;
      int s;
      if (rst) begin
         m_valid = 1; m_as_p1 = 0; m_as_p2 = 0; m_tm_p1 = 0; m_tm_p2 = 0;
         m_primed = 0; m_waitneg = 1; m_in_bus = 0; m_done = 0; m_native = 0;
         m_age = 0; m_sel = 0; m_berr = 0; m_ovl = 1;
         return;
      end
      as_s = m_as_p2;
      term_s = m_tm_p2;
      if (m_waitneg) begin
         if (m_primed >= 2 && !as_s) m_waitneg = 0;
      end else if (!m_in_bus) begin
         if (as_s) begin
            s = model_sel(bus_if.ADDR, bus_if.RnW, bus_if.FC, bus_if.RAMTOP, m_ovl, nat);
            m_sel = s; m_native = nat; m_in_bus = 1; m_done = 0; m_age = 0;
         end
      end else if (!as_s) begin
         if (m_native) m_ovl = 0;
         m_in_bus = 0; m_sel = 0; m_berr = 0; m_native = 0;
      end else if (!m_done) begin
         m_age++;
         if (term_s) m_done = 1;
         else if (m_age == TMO) begin
            m_berr = 1;
            m_done = 1;
         end
      end
      m_as_p2 = m_as_p1; m_as_p1 = ~bus_if.cpu_nAS;
      m_tm_p2 = m_tm_p1; m_tm_p1 = bus_if.TERM_ANY;
      if (m_primed < 2) m_primed++;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         check("cmp_outputs",
               {bus_if.nRAMSEL, bus_if.nROMSEL, bus_if.nIOSEL, bus_if.BERR, bus_if.OVERLAY},
               {5'(m_sel != 1) << 4 | 5'(m_sel != 2) << 3 | 5'(m_sel != 3) << 2
                | 5'(m_berr) << 1 | 5'(m_ovl)});
         check("cmp_exclusive",
               32'(int'(!bus_if.nRAMSEL) + int'(!bus_if.nROMSEL) + int'(!bus_if.nIOSEL) <= 1), 1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_cycle(input logic [31:0] a, input logic rnw, input logic [2:0] fc);
      bus_if.ADDR    = a;
      bus_if.RnW     = rnw;
      bus_if.FC      = fc;
      bus_if.cpu_nAS = 1'b0;
   endtask

   task automatic end_cycle();
      bus_if.cpu_nAS  = 1'b1;
      bus_if.TERM_ANY = 1'b0;
   endtask

   task automatic short_cycle(input logic [31:0] a, input logic rnw, input logic [2:0] fc);
      start_cycle(a, rnw, fc);
      tick(3);
      bus_if.TERM_ANY = 1'b1;
      tick(3);
      end_cycle();
      tick(5);
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0; failures = 0; m_valid = 0;
      rst = 1'b1;
      bus_if.cpu_nAS = 1'b1; bus_if.RnW = 1'b1; bus_if.FC = 3'b101;
      bus_if.ADDR = '0; bus_if.RAMTOP = 5'd1; bus_if.TERM_ANY = 1'b0;
      tick(2);
      check("rst_selects", {bus_if.nRAMSEL, bus_if.nROMSEL, bus_if.nIOSEL}, 3'b111);
      check("rst_berr", bus_if.BERR, 0);
      check("rst_overlay", bus_if.OVERLAY, 1);
      check("model_rst_overlay", m_ovl, 1);
      rst = 1'b0;
      tick(5);

      // native ROM window read clears overlay on exit
      start_cycle(32'hF000_0004, 1'b1, 3'b101);
      tick(2);
      check("rom_latency", bus_if.nROMSEL, 1);
      tick(1);
      check("rom_sel", bus_if.nROMSEL, 0);
      check("model_rom_sel", m_sel, 2);
      bus_if.TERM_ANY = 1'b1;
      tick(4);
      check("rom_hold", bus_if.nROMSEL, 0);
      end_cycle();
      tick(2);
      check("ovl_before_exit", bus_if.OVERLAY, 1);
      tick(1);
      check("rom_exit", bus_if.nROMSEL, 1);
      check("ovl_cleared", bus_if.OVERLAY, 0);
      check("model_ovl_cleared", m_ovl, 0);
      tick(2);

      // address 0 now reaches RAM; reset mid-cycle
      start_cycle(32'h0000_0000, 1'b1, 3'b101);
      tick(3);
      check("ram_at_zero", bus_if.nRAMSEL, 0);
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rst_mid_selects", {bus_if.nRAMSEL, bus_if.nROMSEL, bus_if.nIOSEL}, 3'b111);
      check("rst_mid_overlay", bus_if.OVERLAY, 1);
      tick(8);
      check("rst_no_redecode", bus_if.nRAMSEL, 1);
      end_cycle();
      tick(5);
      start_cycle(32'h0000_0000, 1'b1, 3'b101);
      tick(3);
      check("post_rst_overlay_rom", {bus_if.nRAMSEL, bus_if.nROMSEL}, 2'b10);
      bus_if.TERM_ANY = 1'b1;
      tick(2);
      end_cycle();
      tick(5);

      // overlay: writes go to RAM, reads to ROM
      start_cycle(32'h0000_0100, 1'b0, 3'b101);
      tick(3);
      check("ovl_write_ram", {bus_if.nRAMSEL, bus_if.nROMSEL}, 2'b01);
      bus_if.TERM_ANY = 1'b1;
      tick(2);
      end_cycle();
      tick(5);
      start_cycle(32'h0000_0100, 1'b1, 3'b101);
      tick(3);
      check("ovl_read_rom", {bus_if.nRAMSEL, bus_if.nROMSEL}, 2'b10);
      bus_if.TERM_ANY = 1'b1;
      tick(2);
      end_cycle();
      tick(5);
      check("ovl_kept", bus_if.OVERLAY, 1);

      // watchdog: no termination
      bus_if.RAMTOP = 5'd2;
      start_cycle(32'h0200_0000, 1'b1, 3'b101);
      tick(3);
      check("unpop_no_sel", {bus_if.nRAMSEL, bus_if.nROMSEL, bus_if.nIOSEL}, 3'b111);
      tick(TMO - 1);
      check("berr_before", bus_if.BERR, 0);
      tick(1);
      check("berr_at_256", bus_if.BERR, 1);
      check("model_berr_at_256", m_berr, 1);
      tick(20);
      check("berr_held", bus_if.BERR, 1);
      end_cycle();
      tick(2);
      check("berr_until_exit", bus_if.BERR, 1);
      tick(1);
      check("berr_released", bus_if.BERR, 0);
      tick(3);

      // termination in the same cycle as the timeout wins
      start_cycle(32'h0200_0000, 1'b1, 3'b101);
      tick(3 + TMO - 3);
      bus_if.TERM_ANY = 1'b1;
      tick(3);
      check("term_wins", bus_if.BERR, 0);
      tick(10);
      check("term_wins_hold", bus_if.BERR, 0);
      end_cycle();
      tick(5);

      // termination one cycle too late
      start_cycle(32'h0200_0000, 1'b1, 3'b101);
      tick(3 + TMO - 2);
      bus_if.TERM_ANY = 1'b1;
      tick(3);
      check("late_term_berr", bus_if.BERR, 1);
      end_cycle();
      tick(5);

      // CPU space with AVEC
      bus_if.TERM_ANY = 1'b1;
      start_cycle(32'hFFFF_FFF5, 1'b1, 3'b111);
      tick(3);
      check("cpu_space_sel", {bus_if.nRAMSEL, bus_if.nROMSEL, bus_if.nIOSEL, bus_if.BERR}, 4'b1110);
      tick(5);
      check("cpu_space_hold", {bus_if.nRAMSEL, bus_if.nROMSEL, bus_if.nIOSEL, bus_if.BERR}, 4'b1110);
      end_cycle();
      tick(5);

      // RAMTOP boundary, clamp and I/O window
      bus_if.RAMTOP = 5'd3;
      short_cycle(32'h0200_0000, 1'b1, 3'b101);
      bus_if.RAMTOP = 5'd20;
      short_cycle(32'h0FFF_FFFC, 1'b1, 3'b101);
      short_cycle(32'h1000_0000, 1'b1, 3'b101);
      short_cycle(32'hF010_0010, 1'b0, 3'b101);
      start_cycle(32'hF01F_FFFC, 1'b1, 3'b101);
      tick(3);
      check("io_sel", {bus_if.nRAMSEL, bus_if.nROMSEL, bus_if.nIOSEL}, 3'b110);
      bus_if.TERM_ANY = 1'b1;
      tick(2);
      end_cycle();
      tick(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
